qdr_cal_sampler: RTL and testbench
==================================

Name: qdr_cal_sampler

Overview:
- Datapath side of the QDR software-calibration loop; sits directly downstream of the Wishbone calibration register block.
- Consumes that block's control outputs: cal_en, bit_select, the delay strobes and the align strobes.
- Steers IODELAY tap/reset strobes and half-cycle align selects to the selected data bit.
- Samples that bit's rise/fall capture SAMPLE_COUNT times and returns cal_rdy, data_in, data_sampled and data_valid to the register block.

Parameters:
- DATA_WIDTH, 36, QDR read data width; legal bit_select range is 0..DATA_WIDTH-1.
- SAMPLE_COUNT, 32, consecutive samples per measurement (2..255).
- SETTLE_CYCLES, 16, wait after a trigger before sampling (1..255); covers IODELAY update and the 2-cycle input pipeline.
- RDY_DELAY, 1024, cycles cal_en must be high before cal_rdy asserts (DLL relock wait).

Ports:
- clk  in  1  QDR fabric clock; sole clock.
- reset  in  1  synchronous, active-high.
- cal_en  in  1  calibration enable (level).
- bit_select  in  8  bit under calibration.
- dll_en  in  1  single-cycle tap strobe.
- dll_inc_dec_n  in  1  tap direction: 1 = increment.
- dll_rst  in  1  IODELAY reset request (level).
- align_en  in  1  align value for the selected bit.
- align_strb  in  1  single-cycle load of align_en.
- qdr_q_rise  in  DATA_WIDTH  rising-edge capture.
- qdr_q_fall  in  DATA_WIDTH  falling-edge capture.
- cal_rdy  out  1  calibration ready.
- data_in  out  2  {fall,rise} of the last sample.
- data_sampled  out  1  measurement complete.
- data_valid  out  1  all samples identical.
- dly_ce  out  DATA_WIDTH  per-bit IODELAY CE pulse.
- dly_inc  out  1  IODELAY INC.
- dly_rst  out  DATA_WIDTH  per-bit IODELAY reset.
- align_sel  out  DATA_WIDTH  per-bit half-cycle align select.
- glitch_count  out  8  mismatch count (optional feature).

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high on port reset.
- Reset clears every output to 0 and forces state IDLE.
- Input pipeline:
  - Stage 1: qdr_q_rise and qdr_q_fall registered.
  - Stage 2: {fall,rise}[bit_select] registered. This gives 2-cycle latency from pins to the compare point.
  - bit_select >= DATA_WIDTH: muxed value is 2'b00; no dly_ce, dly_rst or align_sel bit is affected.
- Strobe steering, all registered with 1-cycle latency:
  - dly_ce[i] = dll_en & (bit_select==i); one-hot or zero.
  - dly_inc = dll_inc_dec_n.
  - dly_rst[i] = dll_rst & (bit_select==i).
  - align_strb: align_sel[bit_select] <= align_en; all other bits hold.
  - Steering is active regardless of cal_en.
- cal_rdy:
  - An 11-bit counter runs while cal_en=1 and saturates at RDY_DELAY; cal_rdy=1 once it reaches RDY_DELAY.
  - cal_en=0 clears the counter and cal_rdy on the next edge.
- Trigger (any of these, evaluated each cycle): dll_en, align_strb, falling edge of dll_rst, bit_select differing from its value on the previous cycle.
- FSM:
  - IDLE: outputs held. Go to SETTLE on a trigger when cal_rdy=1.
  - SETTLE: count SETTLE_CYCLES, then go to SAMPLE.
  - SAMPLE:
    - First cycle latches the reference value and sets the match flag to 1.
    - Each of the SAMPLE_COUNT cycles clears the match flag if the sample differs from the reference.
    - data_in updates every sample.
    - After SAMPLE_COUNT samples, go to DONE.
  - DONE: data_sampled=1, data_valid=match flag; both held until the next trigger.
- Every trigger clears data_sampled and data_valid on the next edge and enters SETTLE.
  - A trigger during SETTLE or SAMPLE restarts SETTLE and discards the partial measurement.
  - Simultaneous triggers count as one.
- cal_en=0 in any state goes to IDLE next cycle and clears data_sampled and data_valid; data_in holds its value.
- Counters: the settle counter is 8 bits and the sample counter is 8 bits. No wrap occurs, since the parameter range is bounded.

Optional Feature:
- QDR_CAL_GLITCH_CNT_EN defined:
  - glitch_count counts mismatching samples in the current measurement, saturating at 255.
  - It clears on every trigger and holds in DONE.
- Undefined: glitch_count is tied to 0 and the counter logic is not built.

Test Plan:
- Reset and ready: reset, then cal_en=1 -> all outputs 0; cal_rdy rises exactly RDY_DELAY cycles after cal_en; cal_en=0 -> cal_rdy 0 next cycle.
- Stable bit: bit_select=5, rise[5]=1, fall[5]=0 constant, dll_en pulse -> data_sampled=1 at SETTLE_CYCLES+32+1 cycles after the pulse, data_valid=1, data_in=2'b01; dly_ce=36'h20 for exactly one cycle.
- Glitch: same setup with fall[5] toggled for one cycle mid-sample -> data_sampled=1, data_valid=0; glitch_count=1 with QDR_CAL_GLITCH_CNT_EN defined.
- Restart: dll_en pulse during sample 10, then another pulse -> no data_sampled from the first pulse; completion at SETTLE_CYCLES+33 cycles after the second pulse.
- Align and out-of-range select: bit_select=35, align_en=1, align_strb -> align_sel=36'h8_0000_0000. Then bit_select=40 with dll_en and align_strb -> dly_ce and align_sel unchanged, data_in=2'b00, data_valid=1.
- Reset mid-SAMPLE: reset -> IDLE, data_sampled=0, align_sel=0, cal_rdy=0.

Source files
------------

// File: rtl/qdr_cal_sampler.sv
// qdr_cal_sampler: steers IODELAY/align strobes to one QDR read bit and measures its capture stability.
// Define QDR_CAL_GLITCH_CNT_EN to build the per-measurement mismatch counter driving glitch_count.
module qdr_cal_sampler #(
   parameter int DATA_WIDTH    = 36,
   parameter int SAMPLE_COUNT  = 32,
   parameter int SETTLE_CYCLES = 16,
   parameter int RDY_DELAY     = 1024
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  cal_en,
   input  logic [7:0]            bit_select,
   input  logic                  dll_en,
   input  logic                  dll_inc_dec_n,
   input  logic                  dll_rst,
   input  logic                  align_en,
   input  logic                  align_strb,
   input  logic [DATA_WIDTH-1:0] qdr_q_rise,
   input  logic [DATA_WIDTH-1:0] qdr_q_fall,
   output logic                  cal_rdy,
   output logic [1:0]            data_in,
   output logic                  data_sampled,
   output logic                  data_valid,
   output logic [DATA_WIDTH-1:0] dly_ce,
   output logic                  dly_inc,
   output logic [DATA_WIDTH-1:0] dly_rst,
   output logic [DATA_WIDTH-1:0] align_sel,
   output logic [7:0]            glitch_count
);

   localparam logic [1:0]  ST_IDLE     = 2'd0;
   localparam logic [1:0]  ST_SETTLE   = 2'd1;
   localparam logic [1:0]  ST_SAMPLE   = 2'd2;
   localparam logic [1:0]  ST_DONE     = 2'd3;
   localparam logic [7:0]  SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
   localparam logic [7:0]  SAMPLE_LAST = 8'(SAMPLE_COUNT - 1);
   localparam logic [10:0] RDY_MAX     = 11'(RDY_DELAY);

   logic [DATA_WIDTH-1:0] q_rise_r;
   logic [DATA_WIDTH-1:0] q_fall_r;
   logic [1:0]            sample_r;
   logic [1:0]            ref_r;
   logic                  match_r;
   logic [7:0]            bit_sel_prev_r;
   logic                  dll_rst_prev_r;
   logic [10:0]           rdy_cnt_r;
   logic [1:0]            state_r;
   logic [7:0]            settle_cnt_r;
   logic [7:0]            sample_cnt_r;

   logic [DATA_WIDTH-1:0] sel_onehot_s;
   logic [1:0]            bit_mux_s;
   logic                  trigger_s;
   logic                  start_s;
   logic                  mismatch_s;

   // One-hot decode of bit_select; an out-of-range select decodes to all zeros.
   always_comb begin
      sel_onehot_s = {DATA_WIDTH{1'b0}};
      for (int i = 0; i < DATA_WIDTH; i++) begin
         sel_onehot_s[i] = (32'(bit_select) == 32'(i));
      end
   end

   // AND-OR mux of the selected bit's {fall,rise} from the first pipeline stage.
   always_comb begin
      bit_mux_s = 2'b00;
      for (int i = 0; i < DATA_WIDTH; i++) begin
         bit_mux_s = bit_mux_s | ({q_fall_r[i], q_rise_r[i]} & {2{sel_onehot_s[i]}});
      end
   end

   // Trigger sources are OR-ed, so coincident events start a single measurement.
   always_comb begin
      trigger_s  = dll_en | align_strb | (dll_rst_prev_r & ~dll_rst) |
                   (bit_select != bit_sel_prev_r);
      start_s    = cal_en & cal_rdy & trigger_s;
      mismatch_s = (sample_r != ref_r);
   end

   // Two-stage capture pipeline plus previous-cycle copies used for edge/change detection.
   always_ff @(posedge clk) begin
      if (reset) begin
         q_rise_r       <= {DATA_WIDTH{1'b0}};
         q_fall_r       <= {DATA_WIDTH{1'b0}};
         sample_r       <= 2'b00;
         bit_sel_prev_r <= 8'd0;
         dll_rst_prev_r <= 1'b0;
      end else begin
         q_rise_r       <= qdr_q_rise;
         q_fall_r       <= qdr_q_fall;
         sample_r       <= bit_mux_s;
         bit_sel_prev_r <= bit_select;
         dll_rst_prev_r <= dll_rst;
      end
   end

   // IODELAY and align steering; independent of cal_en and of the measurement FSM.
   always_ff @(posedge clk) begin
      if (reset) begin
         dly_ce    <= {DATA_WIDTH{1'b0}};
         dly_inc   <= 1'b0;
         dly_rst   <= {DATA_WIDTH{1'b0}};
         align_sel <= {DATA_WIDTH{1'b0}};
      end else begin
         dly_ce  <= dll_en  ? sel_onehot_s : {DATA_WIDTH{1'b0}};
         dly_inc <= dll_inc_dec_n;
         dly_rst <= dll_rst ? sel_onehot_s : {DATA_WIDTH{1'b0}};
         if (align_strb) begin
            align_sel <= (align_sel & ~sel_onehot_s) |
                         (align_en ? sel_onehot_s : {DATA_WIDTH{1'b0}});
         end else begin
            align_sel <= align_sel;
         end
      end
   end

   // DLL relock wait: cal_rdy rises on the same edge the counter reaches RDY_DELAY.
   always_ff @(posedge clk) begin
      if (reset) begin
         rdy_cnt_r <= 11'd0;
         cal_rdy   <= 1'b0;
      end else if (!cal_en) begin
         rdy_cnt_r <= 11'd0;
         cal_rdy   <= 1'b0;
      end else begin
         if (rdy_cnt_r != RDY_MAX) begin
            rdy_cnt_r <= rdy_cnt_r + 11'd1;
         end else begin
            rdy_cnt_r <= rdy_cnt_r;
         end
         cal_rdy <= (rdy_cnt_r >= (RDY_MAX - 11'd1));
      end
   end

   // Measurement FSM: settle, sample against the first sample, then report in DONE.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r      <= ST_IDLE;
         settle_cnt_r <= 8'd0;
         sample_cnt_r <= 8'd0;
         ref_r        <= 2'b00;
         match_r      <= 1'b0;
         data_in      <= 2'b00;
         data_sampled <= 1'b0;
         data_valid   <= 1'b0;
      end else if (!cal_en) begin
         state_r      <= ST_IDLE;
         settle_cnt_r <= 8'd0;
         sample_cnt_r <= 8'd0;
         data_sampled <= 1'b0;
         data_valid   <= 1'b0;
      end else if (start_s) begin
         state_r      <= ST_SETTLE;
         settle_cnt_r <= 8'd0;
         sample_cnt_r <= 8'd0;
         match_r      <= 1'b0;
         data_sampled <= 1'b0;
         data_valid   <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               state_r <= ST_IDLE;
            end
            ST_SETTLE: begin
               if (settle_cnt_r == SETTLE_LAST) begin
                  state_r      <= ST_SAMPLE;
                  sample_cnt_r <= 8'd0;
               end else begin
                  settle_cnt_r <= settle_cnt_r + 8'd1;
               end
            end
            ST_SAMPLE: begin
               data_in <= sample_r;
               if (sample_cnt_r == 8'd0) begin
                  ref_r   <= sample_r;
                  match_r <= 1'b1;
               end else if (mismatch_s) begin
                  match_r <= 1'b0;
               end else begin
                  match_r <= match_r;
               end
               if (sample_cnt_r == SAMPLE_LAST) begin
                  state_r <= ST_DONE;
               end else begin
                  sample_cnt_r <= sample_cnt_r + 8'd1;
               end
            end
            ST_DONE: begin
               data_sampled <= 1'b1;
               data_valid   <= match_r;
            end
            default: begin
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

`ifdef QDR_CAL_GLITCH_CNT_EN
   // Mismatch counter; the reference sample itself is never counted.
   always_ff @(posedge clk) begin
      if (reset) begin
         glitch_count <= 8'd0;
      end else if (start_s) begin
         glitch_count <= 8'd0;
      end else if (cal_en && (state_r == ST_SAMPLE) && (sample_cnt_r != 8'd0) &&
                   mismatch_s && (glitch_count != 8'hFF)) begin
         glitch_count <= glitch_count + 8'd1;
      end else begin
         glitch_count <= glitch_count;
      end
   end
`else
   assign glitch_count = 8'd0;
`endif

endmodule

// File: tb/tb_qdr_cal_sampler.sv
// Directed self-checking bench for qdr_cal_sampler: steering table plus measurement sequences.
module tb_qdr_cal_sampler;

   logic        clk = 1'b0;
   logic        reset;
   logic        cal_en;
   logic [7:0]  bit_select;
   logic        dll_en;
   logic        dll_inc_dec_n;
   logic        dll_rst;
   logic        align_en;
   logic        align_strb;
   logic [35:0] qdr_q_rise;
   logic [35:0] qdr_q_fall;
   logic        cal_rdy;
   logic [1:0]  data_in;
   logic        data_sampled;
   logic        data_valid;
   logic [35:0] dly_ce;
   logic        dly_inc;
   logic [35:0] dly_rst;
   logic [35:0] align_sel;
   logic [7:0]  glitch_count;

   int n_pass  = 0;
   int n_total = 0;
   int early;

`ifdef QDR_CAL_GLITCH_CNT_EN
   localparam logic [7:0] EXP_GLITCH = 8'd1;
`else
   localparam logic [7:0] EXP_GLITCH = 8'd0;
`endif

   typedef struct {
      logic [7:0]  bs;
      logic        en;
      logic        inc;
      logic        rst;
      logic        ae;
      logic        strb;
      logic [35:0] e_ce;
      logic        e_inc;
      logic [35:0] e_rst;
      logic [35:0] e_align;
   } vec_t;

   vec_t vecs[9];

   qdr_cal_sampler dut (
      .clk           (clk),
      .reset         (reset),
      .cal_en        (cal_en),
      .bit_select    (bit_select),
      .dll_en        (dll_en),
      .dll_inc_dec_n (dll_inc_dec_n),
      .dll_rst       (dll_rst),
      .align_en      (align_en),
      .align_strb    (align_strb),
      .qdr_q_rise    (qdr_q_rise),
      .qdr_q_fall    (qdr_q_fall),
      .cal_rdy       (cal_rdy),
      .data_in       (data_in),
      .data_sampled  (data_sampled),
      .data_valid    (data_valid),
      .dly_ce        (dly_ce),
      .dly_inc       (dly_inc),
      .dly_rst       (dly_rst),
      .align_sel     (align_sel),
      .glitch_count  (glitch_count)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   task automatic pulse_dll_en();
      dll_en = 1'b1;
      tick();
      dll_en = 1'b0;
   endtask

   initial begin
      vecs[0] = '{8'd0,   1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 36'h1,  1'b1, 36'h0, 36'h0};
      vecs[1] = '{8'd5,   1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 36'h20, 1'b0, 36'h0, 36'h0};
      vecs[2] = '{8'd35,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 36'h0,  1'b1, 36'h8_0000_0000, 36'h0};
      vecs[3] = '{8'd35,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 36'h0,  1'b0, 36'h0, 36'h8_0000_0000};
      vecs[4] = '{8'd3,   1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 36'h0,  1'b1, 36'h0, 36'h8_0000_0008};
      vecs[5] = '{8'd35,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 36'h0,  1'b0, 36'h0, 36'h0_0000_0008};
      vecs[6] = '{8'd40,  1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 36'h0,  1'b1, 36'h0, 36'h0_0000_0008};
      vecs[7] = '{8'd3,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 36'h0,  1'b0, 36'h0, 36'h0_0000_0008};
      vecs[8] = '{8'd255, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 36'h0,  1'b1, 36'h0, 36'h0_0000_0008};

      reset = 1'b1; cal_en = 1'b0; bit_select = 8'd0; dll_en = 1'b0; dll_inc_dec_n = 1'b0;
      dll_rst = 1'b0; align_en = 1'b0; align_strb = 1'b0;
      qdr_q_rise = 36'h0; qdr_q_fall = 36'h0;
      repeat (3) tick();

      chk("rst_cal_rdy",      64'(cal_rdy),      64'(1'b0));
      chk("rst_data_in",      64'(data_in),      64'(2'b00));
      chk("rst_data_sampled", 64'(data_sampled), 64'(1'b0));
      chk("rst_data_valid",   64'(data_valid),   64'(1'b0));
      chk("rst_dly_ce",       64'(dly_ce),       64'(36'h0));
      chk("rst_dly_inc",      64'(dly_inc),      64'(1'b0));
      chk("rst_dly_rst",      64'(dly_rst),      64'(36'h0));
      chk("rst_align_sel",    64'(align_sel),    64'(36'h0));
      chk("rst_glitch",       64'(glitch_count), 64'(8'd0));
      reset = 1'b0;
      tick();

      // Steering table, with cal_en low.
      for (int v = 0; v < 9; v++) begin
         bit_select = vecs[v].bs; dll_en = vecs[v].en; dll_inc_dec_n = vecs[v].inc;
         dll_rst = vecs[v].rst; align_en = vecs[v].ae; align_strb = vecs[v].strb;
         tick();
         chk($sformatf("vec%0d_dly_ce", v),    64'(dly_ce),    64'(vecs[v].e_ce));
         chk($sformatf("vec%0d_dly_inc", v),   64'(dly_inc),   64'(vecs[v].e_inc));
         chk($sformatf("vec%0d_dly_rst", v),   64'(dly_rst),   64'(vecs[v].e_rst));
         chk($sformatf("vec%0d_align_sel", v), 64'(align_sel), 64'(vecs[v].e_align));
      end
      dll_en = 1'b0; dll_rst = 1'b0; align_en = 1'b0; align_strb = 1'b0;
      tick();

      // cal_rdy rises exactly 1024 edges after cal_en is raised.
      cal_en = 1'b1;
      repeat (1023) tick();
      chk("rdy_before", 64'(cal_rdy), 64'(1'b0));
      tick();
      chk("rdy_at", 64'(cal_rdy), 64'(1'b1));

      // Stable bit 5: rise=1, fall=0.
      bit_select = 8'd5; qdr_q_rise = 36'h20; qdr_q_fall = 36'h0; dll_inc_dec_n = 1'b1;
      repeat (60) tick();
      pulse_dll_en();
      chk("stable_dly_ce_pulse",   64'(dly_ce),       64'(36'h20));
      chk("stable_trig_clears",    64'(data_sampled), 64'(1'b0));
      tick();
      chk("stable_dly_ce_cleared", 64'(dly_ce),       64'(36'h0));
      repeat (47) tick();
      chk("stable_not_yet",        64'(data_sampled), 64'(1'b0));
      tick();
      chk("stable_sampled",        64'(data_sampled), 64'(1'b1));
      chk("stable_valid",          64'(data_valid),   64'(1'b1));
      chk("stable_data_in",        64'(data_in),      64'(2'b01));
      chk("stable_glitch",         64'(glitch_count), 64'(8'd0));
      repeat (6) tick();
      chk("stable_hold",           64'(data_sampled), 64'(1'b1));

      // Glitch: fall[5] high for one cycle in the middle of the sample window.
      pulse_dll_en();
      repeat (29) tick();
      qdr_q_fall = 36'h20;
      tick();
      qdr_q_fall = 36'h0;
      repeat (19) tick();
      chk("glitch_sampled", 64'(data_sampled), 64'(1'b1));
      chk("glitch_valid",   64'(data_valid),   64'(1'b0));
      chk("glitch_count",   64'(glitch_count), 64'(EXP_GLITCH));
      chk("glitch_data_in", 64'(data_in),      64'(2'b01));

      // Restart: second pulse lands on sample 10 of the first measurement.
      pulse_dll_en();
      repeat (26) tick();
      pulse_dll_en();
      early = 0;
      for (int k = 1; k <= 48; k++) begin
         tick();
         if (data_sampled) early++;
      end
      chk("restart_no_early_done", 64'(early),        64'(0));
      tick();
      chk("restart_sampled",       64'(data_sampled), 64'(1'b1));
      chk("restart_valid",         64'(data_valid),   64'(1'b1));

      // Dropping cal_en clears ready and results but keeps data_in.
      cal_en = 1'b0;
      tick();
      chk("calen_off_rdy",     64'(cal_rdy),      64'(1'b0));
      chk("calen_off_sampled", 64'(data_sampled), 64'(1'b0));
      chk("calen_off_valid",   64'(data_valid),   64'(1'b0));
      chk("calen_off_data_in", 64'(data_in),      64'(2'b01));
      cal_en = 1'b1;
      repeat (1024) tick();
      chk("rdy_again", 64'(cal_rdy), 64'(1'b1));

      // Align bit 35, then an out-of-range select.
      bit_select = 8'd35; align_en = 1'b1; align_strb = 1'b1;
      tick();
      align_en = 1'b0; align_strb = 1'b0;
      chk("align35", 64'(align_sel), 64'(36'h8_0000_0008));
      repeat (5) tick();
      bit_select = 8'd40; dll_en = 1'b1; align_strb = 1'b1;
      tick();
      dll_en = 1'b0; align_strb = 1'b0;
      chk("oor_dly_ce",    64'(dly_ce),    64'(36'h0));
      chk("oor_align_sel", 64'(align_sel), 64'(36'h8_0000_0008));
      repeat (48) tick();
      chk("oor_not_yet",   64'(data_sampled), 64'(1'b0));
      tick();
      chk("oor_sampled",   64'(data_sampled), 64'(1'b1));
      chk("oor_data_in",   64'(data_in),      64'(2'b00));
      chk("oor_valid",     64'(data_valid),   64'(1'b1));

      // Reset while sampling bit 5.
      bit_select = 8'd5;
      tick();
      repeat (25) tick();
      chk("pre_reset_data_in", 64'(data_in), 64'(2'b01));
      reset = 1'b1;
      tick();
      chk("midrst_sampled",   64'(data_sampled), 64'(1'b0));
      chk("midrst_valid",     64'(data_valid),   64'(1'b0));
      chk("midrst_align_sel", 64'(align_sel),    64'(36'h0));
      chk("midrst_cal_rdy",   64'(cal_rdy),      64'(1'b0));
      chk("midrst_data_in",   64'(data_in),      64'(2'b00));
      reset = 1'b0;
      repeat (60) tick();
      chk("midrst_idle", 64'(data_sampled), 64'(1'b0));

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
